// File: rtl/store_write_buffer_pkg.sv
// Shared types and constants for the store write buffer: RV32 store width
// codes, default depth and the layout of one buffered entry.
package store_write_buffer_pkg;

    localparam logic [2:0] FUNCT3_SB = 3'b000;
    localparam logic [2:0] FUNCT3_SH = 3'b001;
    localparam logic [2:0] FUNCT3_SW = 3'b010;

    localparam int SWB_DEPTH_DEFAULT = 2;

    // Only the word address is kept; byte position is carried by the enables.
    typedef struct packed {
        logic [29:0] word;
        logic [31:0] data;
        logic [3:0]  be;
    } swb_entry_t;

    function automatic logic [31:0] word_to_byte_addr(input logic [29:0] word);
        return {word, 2'b00};
    endfunction

endpackage

// File: rtl/store_write_buffer_if.sv
// Store-request, data-cache write and load-hazard signals of the store buffer.
// The buffer itself takes the slave view; the pipeline/cache side is master.
interface store_write_buffer_if;

    logic        st_valid;
    logic        st_ready;
    logic [2:0]  st_funct3;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_err;

    logic        mem_wvalid;
    logic        mem_wready;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wbe;

    logic [31:0] ld_addr;
    logic        ld_hazard;
    logic        empty;

    modport slave (
        input  st_valid, st_funct3, st_addr, st_data, mem_wready, ld_addr,
        output st_ready, st_err, mem_wvalid, mem_waddr, mem_wdata, mem_wbe,
               ld_hazard, empty
    );

    modport master (
        output st_valid, st_funct3, st_addr, st_data, mem_wready, ld_addr,
        input  st_ready, st_err, mem_wvalid, mem_waddr, mem_wdata, mem_wbe,
               ld_hazard, empty
    );

endinterface

// File: rtl/store_write_buffer_lane_align.sv
// Combinational lane steering: replicates store data across byte lanes and
// builds byte enables, flagging misaligned or unknown store widths.
module store_lane_align
    import store_write_buffer_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] data_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  wbe_o,
    output logic        misaligned_o
);

    always_comb begin
        wdata_o      = data_i;
        wbe_o        = 4'b0000;
        misaligned_o = 1'b0;
        case (funct3_i)
            FUNCT3_SB: begin
                wdata_o = {4{data_i[7:0]}};
                wbe_o   = 4'b0001 << addr_lo_i;
            end
            FUNCT3_SH: begin
                wdata_o      = {2{data_i[15:0]}};
                wbe_o        = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                misaligned_o = addr_lo_i[0];
            end
            FUNCT3_SW: begin
                wdata_o      = data_i;
                wbe_o        = 4'b1111;
                misaligned_o = (addr_lo_i != 2'b00);
            end
            default: begin
                misaligned_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/store_write_buffer.sv
// FIFO of aligned stores between the pipeline and the data cache, with a
// word-granular load hazard check against every buffered entry.
module store_write_buffer
    import store_write_buffer_pkg::*;
#(
    parameter int DEPTH = SWB_DEPTH_DEFAULT
) (
    input  logic                 clock,
    input  logic                 reset,
    store_write_buffer_if.slave  bus
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef logic [PW-1:0] ptr_t;
    typedef logic [PW:0]   cnt_t;

    swb_entry_t       entry_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    ptr_t             head_q, head_d;
    ptr_t             tail_q, tail_d;
    cnt_t             count_q, count_d;
    logic             st_err_q;

    logic [31:0] align_wdata;
    logic [3:0]  align_wbe;
    logic        align_misaligned;

    logic accept, enq, deq, empty_w;

    store_lane_align u_lane_align (
        .funct3_i     (bus.st_funct3),
        .addr_lo_i    (bus.st_addr[1:0]),
        .data_i       (bus.st_data),
        .wdata_o      (align_wdata),
        .wbe_o        (align_wbe),
        .misaligned_o (align_misaligned)
    );

    assign empty_w      = (count_q == '0);
    assign bus.st_ready = (count_q < cnt_t'(DEPTH));
    assign accept       = bus.st_valid && bus.st_ready;
    assign enq          = accept && !align_misaligned;
    assign deq          = !empty_w && bus.mem_wready;

    always_comb begin
        head_d  = deq ? head_q + ptr_t'(1) : head_q;
        tail_d  = enq ? tail_q + ptr_t'(1) : tail_q;
        count_d = count_q;
        case ({enq, deq})
            2'b10:   count_d = count_q + cnt_t'(1);
            2'b01:   count_d = count_q - cnt_t'(1);
            default: count_d = count_q;
        endcase
    end

    // Enqueue and dequeue never target the same slot: enqueue needs a free
    // slot and dequeue needs a full one.
    always_ff @(posedge clock) begin
        if (!reset) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            valid_q  <= '0;
            st_err_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            st_err_q <= accept && align_misaligned;
            if (deq) begin
                valid_q[head_q] <= 1'b0;
            end
            if (enq) begin
                valid_q[tail_q] <= 1'b1;
                entry_q[tail_q] <= '{word: bus.st_addr[31:2],
                                     data: align_wdata,
                                     be:   align_wbe};
            end
        end
    end

    swb_entry_t head_entry;
    assign head_entry = entry_q[head_q];

    assign bus.mem_wvalid = !empty_w;
    assign bus.mem_waddr  = empty_w ? 32'h0 : word_to_byte_addr(head_entry.word);
    assign bus.mem_wdata  = empty_w ? 32'h0 : head_entry.data;
    assign bus.mem_wbe    = empty_w ? 4'h0  : head_entry.be;
    assign bus.st_err     = st_err_q;
    assign bus.empty      = empty_w;

    // Only registered entries are compared, so a store arriving this cycle
    // cannot raise the hazard until it is actually buffered.
    logic [DEPTH-1:0] hit;
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hazard
            assign hit[gi] = valid_q[gi] && (entry_q[gi].word == bus.ld_addr[31:2]);
        end
    endgenerate

    assign bus.ld_hazard = |hit;

    logic unused_ld_lo;
    assign unused_ld_lo = ^bus.ld_addr[1:0];

endmodule

// File: tb/tb_store_write_buffer.sv
// Directed bench for store_write_buffer (DEPTH=2) with hand-computed results.
module tb_store_write_buffer;
    import store_write_buffer_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    store_write_buffer_if bus();

    store_write_buffer #(.DEPTH(2)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic put(input logic v, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
        bus.st_valid  = v;
        bus.st_funct3 = f;
        bus.st_addr   = a;
        bus.st_data   = d;
        if (v) $display("store f3=%0d addr=%h data=%h", f, a, d);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.st_valid   = 1'b0;
        bus.st_funct3  = 3'b000;
        bus.st_addr    = 32'h0;
        bus.st_data    = 32'h0;
        bus.mem_wready = 1'b0;
        bus.ld_addr    = 32'h0;
        reset          = 1'b0;
        tick();
        tick();
        chk("rst_st_ready",   32'(bus.st_ready),   32'h1);
        chk("rst_st_err",     32'(bus.st_err),     32'h0);
        chk("rst_mem_wvalid", 32'(bus.mem_wvalid), 32'h0);
        chk("rst_mem_waddr",  bus.mem_waddr,       32'h0);
        chk("rst_mem_wdata",  bus.mem_wdata,       32'h0);
        chk("rst_mem_wbe",    32'(bus.mem_wbe),    32'h0);
        chk("rst_ld_hazard",  32'(bus.ld_hazard),  32'h0);
        chk("rst_empty",      32'(bus.empty),      32'h1);
        reset = 1'b1;
        tick();

        // SB lane 3, cache ready
        bus.mem_wready = 1'b1;
        put(1'b1, FUNCT3_SB, 32'h0000_0103, 32'h0000_00A5);
        chk("sb_not_fallthrough", 32'(bus.empty), 32'h1);
        tick();
        put(1'b0, FUNCT3_SB, 32'h0, 32'h0);
        chk("sb_wvalid", 32'(bus.mem_wvalid), 32'h1);
        chk("sb_waddr",  bus.mem_waddr,       32'h0000_0100);
        chk("sb_wdata",  bus.mem_wdata,       32'hA5A5_A5A5);
        chk("sb_wbe",    32'(bus.mem_wbe),    32'h8);
        tick();
        chk("sb_drained", 32'(bus.empty), 32'h1);

        // SH upper half, then misaligned SH
        bus.mem_wready = 1'b0;
        put(1'b1, FUNCT3_SH, 32'h0000_0202, 32'h0000_1234);
        tick();
        put(1'b0, FUNCT3_SH, 32'h0, 32'h0);
        chk("sh_waddr", bus.mem_waddr,    32'h0000_0200);
        chk("sh_wdata", bus.mem_wdata,    32'h1234_1234);
        chk("sh_wbe",   32'(bus.mem_wbe), 32'hC);
        bus.mem_wready = 1'b1;
        tick();
        chk("sh_drained", 32'(bus.empty), 32'h1);
        put(1'b1, FUNCT3_SH, 32'h0000_0201, 32'h0000_1234);
        chk("sh_mis_err_not_early", 32'(bus.st_err), 32'h0);
        tick();
        put(1'b0, FUNCT3_SH, 32'h0, 32'h0);
        chk("sh_mis_err",   32'(bus.st_err), 32'h1);
        chk("sh_mis_empty", 32'(bus.empty),  32'h1);
        tick();
        chk("sh_mis_err_pulse", 32'(bus.st_err), 32'h0);

        // Fill to full with cache stalled, then drain in order
        bus.mem_wready = 1'b0;
        put(1'b1, FUNCT3_SW, 32'h0000_0400, 32'h1111_1111);
        tick();
        chk("fill1_ready", 32'(bus.st_ready), 32'h1);
        put(1'b1, FUNCT3_SW, 32'h0000_0404, 32'h2222_2222);
        tick();
        chk("fill2_ready", 32'(bus.st_ready), 32'h0);
        put(1'b1, FUNCT3_SW, 32'h0000_0408, 32'h3333_3333);
        tick();
        chk("full_ready_held", 32'(bus.st_ready), 32'h0);
        chk("stall_waddr",     bus.mem_waddr,     32'h0000_0400);
        chk("stall_wdata",     bus.mem_wdata,     32'h1111_1111);
        bus.mem_wready = 1'b1;
        #1;
        tick();
        chk("drain1_waddr", bus.mem_waddr,     32'h0000_0404);
        chk("drain1_wdata", bus.mem_wdata,     32'h2222_2222);
        chk("drain1_ready", 32'(bus.st_ready), 32'h1);
        tick();
        put(1'b0, FUNCT3_SW, 32'h0, 32'h0);
        chk("simul_waddr", bus.mem_waddr,     32'h0000_0408);
        chk("simul_wdata", bus.mem_wdata,     32'h3333_3333);
        chk("simul_count", 32'(bus.st_ready), 32'h1);
        chk("simul_empty", 32'(bus.empty),    32'h0);
        chk("simul_no_err", 32'(bus.st_err),  32'h0);
        tick();
        chk("fill_drained", 32'(bus.empty), 32'h1);

        // Load hazard
        bus.mem_wready = 1'b0;
        put(1'b1, FUNCT3_SW, 32'h0000_0300, 32'hCAFE_F00D);
        tick();
        put(1'b0, FUNCT3_SW, 32'h0, 32'h0);
        bus.ld_addr = 32'h0000_0302;
        #1;
        chk("haz_same_word", 32'(bus.ld_hazard), 32'h1);
        bus.ld_addr = 32'h0000_0304;
        #1;
        chk("haz_next_word", 32'(bus.ld_hazard), 32'h0);
        put(1'b1, FUNCT3_SW, 32'h0000_0304, 32'h0000_BEEF);
        chk("haz_incoming_excluded", 32'(bus.ld_hazard), 32'h0);
        tick();
        put(1'b0, FUNCT3_SW, 32'h0, 32'h0);
        chk("haz_second_entry", 32'(bus.ld_hazard), 32'h1);
        bus.mem_wready = 1'b1;
        tick();
        tick();
        chk("haz_drain_empty", 32'(bus.empty),     32'h1);
        chk("haz_after_drain", 32'(bus.ld_hazard), 32'h0);

        // Unknown funct3 and misaligned SW, then SB lane 1
        put(1'b1, 3'b011, 32'h0000_0500, 32'h0000_0001);
        tick();
        put(1'b0, FUNCT3_SW, 32'h0, 32'h0);
        chk("bad_f3_err",   32'(bus.st_err), 32'h1);
        chk("bad_f3_empty", 32'(bus.empty),  32'h1);
        put(1'b1, FUNCT3_SW, 32'h0000_0502, 32'h0000_0001);
        tick();
        put(1'b0, FUNCT3_SW, 32'h0, 32'h0);
        chk("sw_mis_err",   32'(bus.st_err), 32'h1);
        chk("sw_mis_empty", 32'(bus.empty),  32'h1);
        bus.mem_wready = 1'b0;
        put(1'b1, FUNCT3_SB, 32'h0000_0101, 32'h0000_005A);
        tick();
        put(1'b0, FUNCT3_SB, 32'h0, 32'h0);
        chk("sb1_wbe",   32'(bus.mem_wbe), 32'h2);
        chk("sb1_wdata", bus.mem_wdata,    32'h5A5A_5A5A);
        chk("sb1_err",   32'(bus.st_err),  32'h0);
        bus.mem_wready = 1'b1;
        tick();
        chk("sb1_drained", 32'(bus.empty), 32'h1);

        // Reset while two entries pending and a store is being offered
        bus.mem_wready = 1'b0;
        put(1'b1, FUNCT3_SW, 32'h0000_0600, 32'h6666_6666);
        tick();
        put(1'b1, FUNCT3_SW, 32'h0000_0604, 32'h7777_7777);
        tick();
        chk("pre_rst_wvalid", 32'(bus.mem_wvalid), 32'h1);
        put(1'b1, FUNCT3_SW, 32'h0000_0608, 32'h8888_8888);
        bus.mem_wready = 1'b1;
        reset = 1'b0;
        tick();
        chk("mid_rst_empty",  32'(bus.empty),      32'h1);
        chk("mid_rst_wvalid", 32'(bus.mem_wvalid), 32'h0);
        chk("mid_rst_ready",  32'(bus.st_ready),   32'h1);
        chk("mid_rst_wdata",  bus.mem_wdata,       32'h0);
        reset = 1'b1;
        put(1'b0, FUNCT3_SW, 32'h0, 32'h0);
        bus.ld_addr = 32'h0000_0600;
        tick();
        chk("post_rst_empty",  32'(bus.empty),     32'h1);
        chk("post_rst_hazard", 32'(bus.ld_hazard), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
